// File: rtl/robin_pkg.sv
// Shared constants, response record and grant-decode helper for the bank read responder.
package robin_pkg;

  localparam int NUM_BANKS_DEF    = 3;
  localparam int SIZE_BANKI_DEF   = 32;
  localparam int NUM_RD_PORTS_DEF = 8;
  localparam int DATA_W_DEF       = 32;
  localparam int RD_LAT_DEF       = 2;

  // Grant vectors are decoded at the widest supported port count.
  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = 3;

  typedef struct packed {
    logic                    valid;
    logic [PORT_IDX_W-1:0]   port_idx;
    logic [DATA_W_DEF-1:0]   data;
  } rsp_t;

  typedef struct packed {
    logic [PORT_IDX_W-1:0] idx;
    logic                  multi;
  } oh_idx_t;

  function automatic oh_idx_t onehot_lowest_idx(input logic [MAX_PORTS-1:0] vec);
    oh_idx_t r;
    logic    seen;
    r    = '0;
    seen = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (vec[i]) begin
        if (!seen) r.idx = PORT_IDX_W'(i);
        else       r.multi = 1'b1;
        seen = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bank_rd_pipe.sv
// One bank: storage, global write decode, grant capture and the read pipeline.
module bank_rd_pipe
  import robin_pkg::*;
#(
  parameter int BANK_IDX           = 0,
  parameter int SIZE_BANKI         = SIZE_BANKI_DEF,
  parameter int NUM_RD_PORTS       = NUM_RD_PORTS_DEF,
  parameter int DATA_W             = DATA_W_DEF,
  parameter int RD_LAT             = RD_LAT_DEF,
  parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
  parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS_DEF)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD_PORTS-1:0]       i_gnt,
  input  logic [SHIRINA_BANKI-1:0]      i_adr,
  input  logic                          i_wr_en,
  input  logic [SHIRINA_VSEH_BANOK-1:0] i_wr_adr,
  input  logic [DATA_W-1:0]             i_wr_data,
  output rsp_t                          o_rsp,
  output logic                          o_multi
);

  localparam int BASE = BANK_IDX * SIZE_BANKI;

  logic [DATA_W-1:0]        r_mem [SIZE_BANKI];
  logic                     w_acc;
  logic                     w_wr_hit;
  logic [SHIRINA_BANKI-1:0] w_wr_off;
  oh_idx_t                  w_oh;

  assign w_oh     = onehot_lowest_idx(MAX_PORTS'(i_gnt));
  assign w_acc    = |i_gnt;
  assign o_multi  = w_oh.multi;
  // Addresses past the last bank match no bank and are silently dropped.
  assign w_wr_hit = i_wr_en && (int'(i_wr_adr) >= BASE) && (int'(i_wr_adr) < BASE + SIZE_BANKI);
  assign w_wr_off = SHIRINA_BANKI'(i_wr_adr - SHIRINA_VSEH_BANOK'(BASE));

  always_ff @(posedge clk) begin
    if (w_wr_hit) r_mem[w_wr_off] <= i_wr_data;
  end

  if (RD_LAT == 1) begin : g_lat1
    // The top-level output register performs the synchronous read capture.
    always_comb begin
      o_rsp.valid    = w_acc;
      o_rsp.port_idx = w_oh.idx;
      o_rsp.data     = r_mem[i_adr];
    end
  end else begin : g_lat2
    logic                  r_vld_p0;
    logic [PORT_IDX_W-1:0] r_port_p0;
    logic [DATA_W-1:0]     r_data_p0;

    // p0: registered storage output; reads see the word before a same-edge write
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_vld_p0 <= 1'b0;
      else      r_vld_p0 <= w_acc;
    end

    always_ff @(posedge clk) begin
      r_port_p0 <= w_oh.idx;
      r_data_p0 <= r_mem[i_adr];
    end

    always_comb begin
      o_rsp.valid    = r_vld_p0;
      o_rsp.port_idx = r_port_p0;
      o_rsp.data     = r_data_p0;
    end
  end

endmodule

// File: rtl/bank_read_responder.sv
// Bank-side read responder: per-bank read pipelines feeding a per-port lowest-bank
// select, registered read outputs and error flags.
module bank_read_responder
  import robin_pkg::*;
#(
  parameter int NUM_BANKS          = NUM_BANKS_DEF,
  parameter int SIZE_BANKI         = SIZE_BANKI_DEF,
  parameter int NUM_RD_PORTS       = NUM_RD_PORTS_DEF,
  parameter int DATA_W             = DATA_W_DEF,
  parameter int RD_LAT             = RD_LAT_DEF,
  parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
  parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS),
  parameter int PORT_W             = $clog2(NUM_RD_PORTS),
  parameter int BANK_W             = $clog2(NUM_BANKS)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]    gnt_robin,
  input  logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]   adr_v_banku,
  input  logic                                      wr_en,
  input  logic [SHIRINA_VSEH_BANOK-1:0]             wr_adr,
  input  logic [DATA_W-1:0]                         wr_data,
  output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]       rd_data,
  output logic [NUM_RD_PORTS-1:0]                   rd_valid,
  output logic [NUM_RD_PORTS-1:0][BANK_W-1:0]       rd_bank,
  output logic                                      err_multi_gnt,
  output logic                                      err_collision
);

  rsp_t                                 w_rsp [NUM_BANKS];
  logic [NUM_BANKS-1:0]                 w_multi;
  logic [NUM_RD_PORTS-1:0]              w_sel_vld;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0]  w_sel_data;
  logic [NUM_RD_PORTS-1:0][BANK_W-1:0]  w_sel_bank;
  logic                                 w_coll;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_rd_pipe #(
      .BANK_IDX           (b),
      .SIZE_BANKI         (SIZE_BANKI),
      .NUM_RD_PORTS       (NUM_RD_PORTS),
      .DATA_W             (DATA_W),
      .RD_LAT             (RD_LAT),
      .SHIRINA_BANKI      (SHIRINA_BANKI),
      .SHIRINA_VSEH_BANOK (SHIRINA_VSEH_BANOK)
    ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .i_gnt     (gnt_robin[b]),
      .i_adr     (adr_v_banku[b]),
      .i_wr_en   (wr_en),
      .i_wr_adr  (wr_adr),
      .i_wr_data (wr_data),
      .o_rsp     (w_rsp[b]),
      .o_multi   (w_multi[b])
    );
  end

  // Ascending bank scan: the first hit on a port wins, any later hit is a collision.
  always_comb begin
    w_sel_vld  = '0;
    w_sel_data = '0;
    w_sel_bank = '0;
    w_coll     = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_rsp[b].valid && (w_rsp[b].port_idx == PORT_IDX_W'(PORT_W'(p)))) begin
          if (w_sel_vld[p]) begin
            w_coll = 1'b1;
          end else begin
            w_sel_vld[p]  = 1'b1;
            w_sel_data[p] = w_rsp[b].data;
            w_sel_bank[p] = BANK_W'(b);
          end
        end
      end
    end
  end

  // output stage: data and bank hold on ports that receive nothing this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid      <= '0;
      rd_data       <= '0;
      rd_bank       <= '0;
      err_collision <= 1'b0;
      err_multi_gnt <= 1'b0;
    end else begin
      rd_valid      <= w_sel_vld;
      err_collision <= w_coll;
      err_multi_gnt <= err_multi_gnt | (|w_multi);
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (w_sel_vld[p]) begin
          rd_data[p] <= w_sel_data[p];
          rd_bank[p] <= w_sel_bank[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_read_responder.sv
// Directed and random stimulus for bank_read_responder against a flat-memory reference model.
module tb_bank_read_responder;

  localparam int NB  = 3;
  localparam int SZ  = 32;
  localparam int NP  = 8;
  localparam int LAT = 2;

  typedef struct packed {
    logic [NP-1:0]       vld;
    logic [NP-1:0][31:0] data;
    logic [NP-1:0][1:0]  bank;
    logic                coll;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic [NB-1:0][NP-1:0] gnt_robin;
  logic [NB-1:0][4:0]    adr_v_banku;
  logic                  wr_en;
  logic [6:0]            wr_adr;
  logic [31:0]           wr_data;
  logic [NP-1:0][31:0]   rd_data;
  logic [NP-1:0]         rd_valid;
  logic [NP-1:0][1:0]    rd_bank;
  logic                  err_multi_gnt;
  logic                  err_collision;

  bank_read_responder dut (
    .clk           (clk),
    .rst           (rst),
    .gnt_robin     (gnt_robin),
    .adr_v_banku   (adr_v_banku),
    .wr_en         (wr_en),
    .wr_adr        (wr_adr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_bank       (rd_bank),
    .err_multi_gnt (err_multi_gnt),
    .err_collision (err_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] gmem [NB*SZ];
  exp_t        q [$];
  logic [31:0] hold_data [NP];
  logic [1:0]  hold_bank [NP];
  logic        exp_multi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    q.delete();
    exp_multi = 1'b0;
    for (int p = 0; p < NP; p++) begin
      hold_data[p] = '0;
      hold_bank[p] = '0;
    end
  endtask

  task automatic chk_zero();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_coll", 32'(err_collision), 32'd0);
    chk("rst_multi", 32'(err_multi_gnt), 32'd0);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rst_data[%0d]", p), rd_data[p], 32'd0);
      chk($sformatf("rst_bank[%0d]", p), 32'(rd_bank[p]), 32'd0);
    end
  endtask

  // One clock: drive inputs, predict responses, advance, compare what is due now.
  task automatic step(input logic [NB-1:0][NP-1:0] g, input logic [NB-1:0][4:0] a,
                      input logic we, input logic [6:0] wa, input logic [31:0] wd);
    exp_t e;
    exp_t cur;
    gnt_robin   = g;
    adr_v_banku = a;
    wr_en       = we;
    wr_adr      = wa;
    wr_data     = wd;
    e = '0;
    for (int b = 0; b < NB; b++) begin
      int s;
      s = lowest(g[b]);
      if (s >= 0) begin
        if (g[b] != (NP'(1) << s)) exp_multi = 1'b1;
        if (e.vld[s]) e.coll = 1'b1;
        else begin
          e.vld[s]  = 1'b1;
          e.data[s] = gmem[b * SZ + int'(a[b])];
          e.bank[s] = 2'(b);
        end
      end
    end
    q.push_back(e);
    if (we && int'(wa) < NB * SZ) gmem[wa] = wd;
    @(posedge clk);
    #1;
    cur = '0;
    if (q.size() >= LAT) cur = q.pop_front();
    for (int p = 0; p < NP; p++) begin
      if (cur.vld[p]) begin
        hold_data[p] = cur.data[p];
        hold_bank[p] = cur.bank[p];
      end
    end
    chk("rd_valid", 32'(rd_valid), 32'(cur.vld));
    chk("err_collision", 32'(err_collision), 32'(cur.coll));
    chk("err_multi_gnt", 32'(err_multi_gnt), 32'(exp_multi));
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rd_data[%0d]", p), rd_data[p], hold_data[p]);
      chk($sformatf("rd_bank[%0d]", p), 32'(rd_bank[p]), 32'(hold_bank[p]));
    end
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 7'd0, 32'd0);
  endtask

  initial begin
    logic [NB-1:0][NP-1:0] g;
    logic [NB-1:0][4:0]    a;
    int                    r;

    rst = 1'b0;
    gnt_robin = '0; adr_v_banku = '0; wr_en = 1'b0; wr_adr = '0; wr_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    rst = 1'b1;

    for (int i = 0; i < NB * SZ; i++) step('0, '0, 1'b1, 7'(i), $urandom);
    idle();
    idle();

    // bank1[5] via global address 37, served on port 2
    step('0, '0, 1'b1, 7'd37, 32'hA5A5_0001);
    g = '0; a = '0; g[1] = 8'b0000_0100; a[1] = 5'd5;
    step(g, a, 1'b0, 7'd0, 32'd0);
    idle();
    chk("tp1_valid", 32'(rd_valid), 32'h04);
    chk("tp1_data", rd_data[2], 32'hA5A5_0001);
    chk("tp1_bank", 32'(rd_bank[2]), 32'd1);

    // back-to-back reads from bank0 to ports 0, 1, 7
    step('0, '0, 1'b1, 7'd0, 32'd10);
    step('0, '0, 1'b1, 7'd1, 32'd11);
    step('0, '0, 1'b1, 7'd2, 32'd12);
    g = '0; a = '0; g[0] = 8'h01; a[0] = 5'd0;
    step(g, a, 1'b0, 7'd0, 32'd0);
    g[0] = 8'h02; a[0] = 5'd1;
    step(g, a, 1'b0, 7'd0, 32'd0);
    chk("b2b_v0", 32'(rd_valid), 32'h01);
    chk("b2b_d0", rd_data[0], 32'd10);
    g[0] = 8'h80; a[0] = 5'd2;
    step(g, a, 1'b0, 7'd0, 32'd0);
    chk("b2b_v1", 32'(rd_valid), 32'h02);
    chk("b2b_d1", rd_data[1], 32'd11);
    idle();
    chk("b2b_v7", 32'(rd_valid), 32'h80);
    chk("b2b_d7", rd_data[7], 32'd12);
    idle();

    // banks 0 and 2 both answer port 3
    step('0, '0, 1'b1, 7'd7, 32'h100);
    step('0, '0, 1'b1, 7'd71, 32'h300);
    g = '0; a = '0; g[0] = 8'h08; g[2] = 8'h08; a[0] = 5'd7; a[2] = 5'd7;
    step(g, a, 1'b0, 7'd0, 32'd0);
    idle();
    chk("coll_flag", 32'(err_collision), 32'd1);
    chk("coll_data", rd_data[3], 32'h100);
    chk("coll_bank", 32'(rd_bank[3]), 32'd0);
    idle();
    chk("coll_pulse", 32'(err_collision), 32'd0);

    // multi-hot grant serves port 5 and sets the sticky flag
    chk("multi_pre", 32'(err_multi_gnt), 32'd0);
    g = '0; a = '0; g[0] = 8'hA0; a[0] = 5'd3;
    step(g, a, 1'b0, 7'd0, 32'd0);
    chk("multi_set", 32'(err_multi_gnt), 32'd1);
    idle();
    chk("multi_port", 32'(rd_valid), 32'h20);
    idle();
    idle();
    chk("multi_sticky", 32'(err_multi_gnt), 32'd1);

    // same-cycle read and write of bank2[0]
    step('0, '0, 1'b1, 7'd64, 32'h11);
    g = '0; a = '0; g[2] = 8'h01; a[2] = 5'd0;
    step(g, a, 1'b1, 7'd64, 32'h22);
    step(g, a, 1'b0, 7'd0, 32'd0);
    chk("raw_old", rd_data[0], 32'h11);
    idle();
    chk("raw_new", rd_data[0], 32'h22);
    step('0, '0, 1'b1, 7'd96, 32'hDEAD_BEEF);
    g = '0; a = '0; g[0] = 8'h01; g[2] = 8'h02;
    step(g, a, 1'b0, 7'd0, 32'd0);
    idle();
    chk("oob_b0", rd_data[0], 32'd10);
    chk("oob_b2", rd_data[1], 32'h22);

    // reset lands while a read is in flight
    g = '0; a = '0; g[1] = 8'h10; a[1] = 5'd4;
    step(g, a, 1'b0, 7'd0, 32'd0);
    gnt_robin = '0;
    #2 rst = 1'b0;
    model_clear();
    #1;
    chk_zero();
    @(posedge clk);
    #1;
    chk_zero();
    #2 rst = 1'b1;
    repeat (4) idle();

    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NB; b++) begin
        r = int'($urandom_range(0, 99));
        if (r < 40)      g[b] = '0;
        else if (r < 90) g[b] = NP'(1) << $urandom_range(0, NP - 1);
        else             g[b] = NP'($urandom);
        a[b] = 5'($urandom);
      end
      step(g, a, ($urandom_range(0, 2) == 0), 7'($urandom_range(0, 127)), $urandom);
    end
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
